gcn_combination_scheduler: RTL and testbench

Sequences the combination phase (feature × weight) of the GCN engine. Owns the shared memory read port (read_address/enable_read) and fetches weight columns into the weight buffer, then fetches feature rows one at a time. For each (row, col) pair it starts the dot-product unit, waits for completion and commands the result-buffer write. Sits between the top-level start/done interface and the datapath, ahead of the aggregation (COO) stage.

---
 rtl/gcn_combination_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_gcn_combination_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gcn_combination_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gcn_combination_scheduler
// Purpose  : Sequences the combination phase (feature x weight) of the GCN
//            engine. It owns the shared memory read port and loads every
//            weight column into the weight buffer. It then walks the feature
//            rows one at a time. For each (row, col) pair it starts the
//            dot-product unit, waits for completion and commands the
//            result-buffer write.
// Ports    : clk             - clock, rising edge
//            reset           - asynchronous active-low reset
//            start           - level request, sampled only in IDLE
//            mac_done        - dot-product unit finished the current job
//            read_address    - memory read address (holds when not reading)
//            enable_read     - memory read strobe
//            weight_load     - load data_in into weight column weight_col_idx
//            feature_load    - load data_in into the feature row register
//            weight_col_idx  - current weight column
//            feature_row_idx - current feature row
//            mac_start       - one-cycle dot-product start pulse
//            result_write_en - write MAC result to [feature_row_idx][weight_col_idx]
//            done            - all FEATURE_ROWS x WEIGHT_COLS results written
//            error           - WAIT watchdog fired
// Config   : GCN_SCHED_TIMEOUT_EN - when defined, a watchdog in WAIT aborts to
//            DONE with error=1 after TIMEOUT_CYCLES cycles without mac_done.
//            When undefined, WAIT waits indefinitely and error is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module gcn_combination_scheduler #(
    parameter int FEATURE_ROWS          = 6,
    parameter int WEIGHT_COLS           = 3,
    parameter int ADDRESS_WIDTH         = 13,
    parameter int FEATURE_BASE          = 512,
    parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
    parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
    parameter int TIMEOUT_CYCLES        = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             mac_done,
    output logic [ADDRESS_WIDTH-1:0]         read_address,
    output logic                             enable_read,
    output logic                             weight_load,
    output logic                             feature_load,
    output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_col_idx,
    output logic [COUNTER_FEATURE_WIDTH-1:0] feature_row_idx,
    output logic                             mac_start,
    output logic                             result_write_en,
    output logic                             done,
    output logic                             error
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD_W = 3'd1;
    localparam logic [2:0] c_LOAD_F = 3'd2;
    localparam logic [2:0] c_ISSUE  = 3'd3;
    localparam logic [2:0] c_WAIT   = 3'd4;
    localparam logic [2:0] c_WRITE  = 3'd5;
    localparam logic [2:0] c_DONE   = 3'd6;

    // Terminal compares use the parameter values, so non-power-of-2 sizes
    // stop exactly at the last index instead of relying on wrap-around.
    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  c_LAST_COL  = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);
    localparam logic [COUNTER_FEATURE_WIDTH-1:0] c_LAST_ROW  = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  c_COL_ONE   = COUNTER_WEIGHT_WIDTH'(1);
    localparam logic [COUNTER_FEATURE_WIDTH-1:0] c_ROW_ONE   = COUNTER_FEATURE_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0]         c_FEAT_BASE = ADDRESS_WIDTH'(FEATURE_BASE);

    logic [2:0]                       r_state;
    logic [2:0]                       w_state_nxt;
    logic [COUNTER_FEATURE_WIDTH-1:0] r_row;
    logic [COUNTER_FEATURE_WIDTH-1:0] w_row_nxt;
    logic [COUNTER_WEIGHT_WIDTH-1:0]  r_col;
    logic [COUNTER_WEIGHT_WIDTH-1:0]  w_col_nxt;
    logic [ADDRESS_WIDTH-1:0]         r_read_address;
    logic [ADDRESS_WIDTH-1:0]         w_addr_nxt;

`ifdef GCN_SCHED_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;
    logic       r_error;
    logic       w_error_nxt;
`endif

    // ------------------------------------------------------------------------
    // State / counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= c_IDLE;
            r_row          <= '0;
            r_col          <= '0;
            r_read_address <= '0;
`ifdef GCN_SCHED_TIMEOUT_EN
            r_wait_cnt     <= '0;
            r_error        <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_row          <= w_row_nxt;
            r_col          <= w_col_nxt;
            r_read_address <= w_addr_nxt;
`ifdef GCN_SCHED_TIMEOUT_EN
            r_wait_cnt     <= w_wait_cnt_nxt;
            r_error        <= w_error_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and counter logic. The read address is computed here, one
    // cycle ahead, so the registered value lines up with the LOAD states and
    // simply holds everywhere else.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_addr_nxt  = r_read_address;
`ifdef GCN_SCHED_TIMEOUT_EN
        w_wait_cnt_nxt = r_wait_cnt;
        w_error_nxt    = r_error;
`endif
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_LOAD_W;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_addr_nxt  = '0;
                end
            end
            c_LOAD_W: begin
                if (r_col == c_LAST_COL) begin
                    w_state_nxt = c_LOAD_F;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_addr_nxt  = c_FEAT_BASE;
                end else begin
                    w_col_nxt   = r_col + c_COL_ONE;
                    w_addr_nxt  = ADDRESS_WIDTH'(r_col + c_COL_ONE);
                end
            end
            c_LOAD_F: begin
                w_state_nxt = c_ISSUE;
            end
            c_ISSUE: begin
                w_state_nxt = c_WAIT;
`ifdef GCN_SCHED_TIMEOUT_EN
                w_wait_cnt_nxt = '0;
`endif
            end
            c_WAIT: begin
                if (mac_done) begin
                    w_state_nxt = c_WRITE;
                end
`ifdef GCN_SCHED_TIMEOUT_EN
                else if (r_wait_cnt == c_TIMEOUT_LAST) begin
                    w_state_nxt = c_DONE;
                    w_error_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
`endif
            end
            c_WRITE: begin
                if (r_col != c_LAST_COL) begin
                    w_state_nxt = c_ISSUE;
                    w_col_nxt   = r_col + c_COL_ONE;
                end else if (r_row != c_LAST_ROW) begin
                    w_state_nxt = c_LOAD_F;
                    w_col_nxt   = '0;
                    w_row_nxt   = r_row + c_ROW_ONE;
                    w_addr_nxt  = c_FEAT_BASE + ADDRESS_WIDTH'(r_row + c_ROW_ONE);
                end else begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                if (!start) begin
                    w_state_nxt = c_IDLE;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
`ifdef GCN_SCHED_TIMEOUT_EN
                    w_error_nxt = 1'b0;
`endif
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode: purely from registered state, no input-to-output path.
    // ------------------------------------------------------------------------
    always_comb begin
        enable_read     = 1'b0;
        weight_load     = 1'b0;
        feature_load    = 1'b0;
        mac_start       = 1'b0;
        result_write_en = 1'b0;
        done            = 1'b0;
        case (r_state)
            c_LOAD_W: begin
                enable_read = 1'b1;
                weight_load = 1'b1;
            end
            c_LOAD_F: begin
                enable_read  = 1'b1;
                feature_load = 1'b1;
            end
            c_ISSUE:  mac_start       = 1'b1;
            c_WRITE:  result_write_en = 1'b1;
            c_DONE:   done            = 1'b1;
            default:  ;
        endcase
    end

    assign read_address    = r_read_address;
    assign weight_col_idx  = r_col;
    assign feature_row_idx = r_row;

`ifdef GCN_SCHED_TIMEOUT_EN
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcn_combination_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gcn_combination_scheduler
// Purpose  : Directed self-checking bench for gcn_combination_scheduler.
//            A negedge monitor checks every read, issue and write against the
//            expected row-major order. A responder returns mac_done a
//            programmable number of cycles after mac_start, holds it high,
//            or never asserts it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcn_combination_scheduler;

    localparam int FR = 6;
    localparam int WC = 3;
    localparam int AW = 13;
    localparam int FB = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          mac_done;
    logic [AW-1:0] read_address;
    logic          enable_read;
    logic          weight_load;
    logic          feature_load;
    logic [1:0]    weight_col_idx;
    logic [2:0]    feature_row_idx;
    logic          mac_start;
    logic          result_write_en;
    logic          done;
    logic          error;

    gcn_combination_scheduler #(
        .FEATURE_ROWS  (FR),
        .WEIGHT_COLS   (WC),
        .ADDRESS_WIDTH (AW),
        .FEATURE_BASE  (FB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .mac_done        (mac_done),
        .read_address    (read_address),
        .enable_read     (enable_read),
        .weight_load     (weight_load),
        .feature_load    (feature_load),
        .weight_col_idx  (weight_col_idx),
        .feature_row_idx (feature_row_idx),
        .mac_start       (mac_start),
        .result_write_en (result_write_en),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {7'd0, read_address, enable_read, weight_load, feature_load,
                weight_col_idx, feature_row_idx, mac_start, result_write_en, done, error};
    endfunction

    function automatic logic [31:0] strobes();
        return {25'd0, enable_read, weight_load, feature_load, mac_start,
                result_write_en, done, error};
    endfunction

    // mac_done responder: 0 = pulse md_delay cycles after mac_start,
    // 2 = held high, 3 = never.
    int md_mode  = 3;
    int md_delay = 1;
    int md_cnt   = 0;
    always @(negedge clk) begin
        if (md_mode == 2) begin
            mac_done = 1'b1;
        end else if (md_mode == 3) begin
            mac_done = 1'b0;
            md_cnt   = 0;
        end else begin
            mac_done = 1'b0;
            if (md_cnt != 0) begin
                md_cnt--;
                if (md_cnt == 0) mac_done = 1'b1;
            end
            if (mac_start) md_cnt = md_delay;
        end
    end

    // Order monitor: reads 0,1,2,512..517; issues/writes (r,c) row-major.
    bit mon_en = 1'b0;
    int rd_idx = 0;
    int iss_idx = 0;
    int wr_idx = 0;
    bit pending = 1'b0;
    always @(negedge clk) begin
        if (!mon_en) begin
            rd_idx  = 0;
            iss_idx = 0;
            wr_idx  = 0;
            pending = 1'b0;
        end else begin
            if (enable_read) begin
                if (rd_idx < WC) begin
                    check("w_addr", read_address, rd_idx);
                    check("w_load", {weight_load, feature_load}, 2);
                    check("w_col", weight_col_idx, rd_idx);
                end else begin
                    check("f_addr", read_address, FB + rd_idx - WC);
                    check("f_load", {weight_load, feature_load}, 1);
                    check("f_row", feature_row_idx, rd_idx - WC);
                end
                rd_idx++;
            end
            if (mac_start) begin
                check("iss_rc", {feature_row_idx, weight_col_idx},
                      (iss_idx / WC) * 4 + (iss_idx % WC));
                pending = 1'b1;
                iss_idx++;
            end
            if (result_write_en) begin
                check("wr_after_issue", pending, 1);
                check("wr_rc", {feature_row_idx, weight_col_idx},
                      (wr_idx / WC) * 4 + (wr_idx % WC));
                pending = 1'b0;
                wr_idx++;
            end
        end
    end

    // Full run from IDLE: checks the done edge, event totals and DONE exit.
    task automatic run_job(input int mode, input int delay, input int exp_edges, input string tag);
        int n;
        @(negedge clk); #1;
        mon_en  = 1'b0;
        md_mode = 3;
        @(negedge clk); #1;
        reset    = 1'b1;
        start    = 1'b1;
        mon_en   = 1'b1;
        md_mode  = mode;
        md_delay = delay;
        n = 0;
        while (n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        check({tag, "_done_edge"}, n, exp_edges);
        @(negedge clk);
        check({tag, "_reads"}, rd_idx, WC + FR);
        check({tag, "_issues"}, iss_idx, WC * FR);
        check({tag, "_writes"}, wr_idx, WC * FR);
        check({tag, "_error"}, error, 0);
        @(posedge clk); #1;
        check({tag, "_done_hold"}, done, 1);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_idle_strobes"}, strobes(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        // 1. Reset and idle
        @(negedge clk); @(negedge clk);
        check("reset_low_outputs", out_vec(), 0);
        #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", out_vec(), 0);
        end

        // 2. mac_done one cycle after each mac_start
        run_job(0, 1, 64, "fast");
        // 3. mac_done five cycles after each mac_start
        run_job(0, 5, 136, "slow");
        // 4. mac_done held high, including ISSUE cycles
        run_job(2, 1, 64, "held");

        // 6. mac_done never asserted
        @(negedge clk); #1;
        mon_en  = 1'b0;
        md_mode = 3;
        @(negedge clk); #1;
        start  = 1'b1;
        mon_en = 1'b1;
`ifdef GCN_SCHED_TIMEOUT_EN
        n = 0;
        while (n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        check("tmo_done_edge", n, 261);
        check("tmo_error", error, 1);
        check("tmo_writes", wr_idx, 0);
        start = 1'b0;
        @(posedge clk); #1;
        check("tmo_clear", {done, error}, 0);
`else
        repeat (300) @(posedge clk);
        #1;
        check("stall_done", done, 0);
        check("stall_error", error, 0);
        check("stall_strobes", strobes(), 0);
        check("stall_issues", iss_idx, 1);
        reset = 1'b0;
        #1;
        check("stall_reset_outputs", out_vec(), 0);
`endif

        // 5. Asynchronous reset during WAIT for row 3
        run_job(0, 5, 136, "pre_abort");
        @(negedge clk); #1;
        mon_en  = 1'b0;
        md_mode = 3;
        @(negedge clk); #1;
        start    = 1'b1;
        mon_en   = 1'b1;
        md_mode  = 0;
        md_delay = 5;
        n = 0;
        while (iss_idx < 10 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        check("abort_reached_row3", (iss_idx >= 10) ? 1 : 0, 1);
        @(posedge clk); #2;
        check("abort_in_wait_row", feature_row_idx, 3);
        check("abort_in_wait_strobes", strobes(), 0);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("abort_async_outputs", out_vec(), 0);
        run_job(0, 1, 64, "restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
